// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: issues at most one data-memory access per instruction and retires it with a writeback strobe.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES cycles in MEM.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      reg_write,
  input  logic                      mem_read,
  input  logic                      mem_to_reg,
  input  logic                      mem_write,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      wb_valid,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_error,
  output logic [1:0]                dbg_state
);

  // Handshake: a bundle transfers on a rising edge where in_valid and in_ready
  // are both 1; in_ready is registered and only high in IDLE, so the upstream
  // stage may change inputs freely in any cycle where in_ready is 0.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                    r_state;
  logic                      r_in_ready;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic [DATA_WIDTH-1:0]     r_alu;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_reg_write;
  logic                      r_use_rdata;
  logic                      r_wb_valid;
  logic                      r_wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]     r_wb_data;
  logic                      r_wb_error;

  logic w_accept;
  logic w_mem_op;
  logic w_rd_write;
  logic w_use_rdata;
  logic w_timeout;

  assign w_accept    = in_valid & r_in_ready;
  assign w_mem_op    = mem_read | mem_write;
  // A store (including read+write) never writes rd, and x0 is never written.
  assign w_rd_write  = reg_write & ~mem_write & (rd != '0);
  assign w_use_rdata = mem_read & ~mem_write & mem_to_reg;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state == S_MEM) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_MEM) begin
      r_cnt <= '0;
    end else if (!mem_ack && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b1;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_alu          <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_use_rdata    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_wb_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_ready  <= 1'b0;
            r_alu       <= alu_result;
            r_rd        <= rd;
            r_reg_write <= w_rd_write;
            r_use_rdata <= w_use_rdata;
            if (w_mem_op) begin
              r_state     <= S_MEM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= mem_write;
              r_mem_addr  <= alu_result[ADDR_WIDTH-1:0];
              r_mem_wdata <= store_data;
            end else begin
              r_state        <= S_WB;
              r_wb_valid     <= 1'b1;
              r_wb_reg_write <= w_rd_write;
              r_wb_rd        <= rd;
              r_wb_data      <= alu_result;
              r_wb_error     <= 1'b0;
            end
          end
        end
        S_MEM: begin
          // An ack arriving on the last allowed cycle takes priority over abort.
          if (mem_ack) begin
            r_state        <= S_WB;
            r_mem_req      <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_reg_write;
            r_wb_rd        <= r_rd;
            r_wb_data      <= r_use_rdata ? mem_rdata : r_alu;
            r_wb_error     <= 1'b0;
          end else if (w_timeout) begin
            r_state        <= S_WB;
            r_mem_req      <= 1'b0;
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= r_rd;
            r_wb_data      <= r_alu;
            r_wb_error     <= 1'b1;
          end
        end
        S_WB: begin
          r_state    <= S_IDLE;
          r_wb_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_req  <= 1'b0;
          r_wb_valid <= 1'b0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_error     = r_wb_error;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table for single instructions plus
// hand sequences for reset-in-flight, stray acks, back-to-back issue and timeout.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        reg_write;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_error;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  mem_stage_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .REG_ADDR_WIDTH(5)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write(reg_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_result(alu_result), .store_data(store_data),
    .rd(rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_error(wb_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=%h want=<empty queue>", nm, act);
    end else begin
      e = exp_q.pop_front();
      check(nm, act, e);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rw, mr, m2r, mw;
    logic [31:0] alu, sd;
    logic [4:0]  rd;
    int          ack_dly;     // extra MEM cycles before the ack cycle
    logic [31:0] rdata;
    logic        e_mem, e_we, e_rw, e_chk_data;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic rw_i, input logic mr_i,
                              input logic m2r_i, input logic mw_i, input logic [31:0] alu_i,
                              input logic [31:0] sd_i, input logic [4:0] rd_i, input int dly_i,
                              input logic [31:0] rdata_i, input logic e_mem_i, input logic e_we_i,
                              input logic e_rw_i, input logic e_chk_i, input logic [31:0] e_data_i);
    vec_t v;
    v.name = nm; v.rw = rw_i; v.mr = mr_i; v.m2r = m2r_i; v.mw = mw_i;
    v.alu = alu_i; v.sd = sd_i; v.rd = rd_i; v.ack_dly = dly_i; v.rdata = rdata_i;
    v.e_mem = e_mem_i; v.e_we = e_we_i; v.e_rw = e_rw_i; v.e_chk_data = e_chk_i;
    v.e_data = e_data_i;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic rw_i, input logic mr_i, input logic m2r_i, input logic mw_i,
                       input logic [31:0] alu_i, input logic [31:0] sd_i, input logic [4:0] rd_i);
    reg_write  = rw_i;
    mem_read   = mr_i;
    mem_to_reg = m2r_i;
    mem_write  = mw_i;
    alu_result = alu_i;
    store_data = sd_i;
    rd         = rd_i;
    in_valid   = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1({v.name, "_ready"}, in_ready, 1'b1);
    if (v.e_chk_data) exp_q.push_back(v.e_data);
    issue(v.rw, v.mr, v.m2r, v.mw, v.alu, v.sd, v.rd);
    @(negedge clk);
    if (v.e_mem) begin
      for (int i = 0; i <= v.ack_dly; i++) begin
        check1({v.name, "_req"}, mem_req, 1'b1);
        check1({v.name, "_we"}, mem_we, v.e_we);
        check({v.name, "_addr"}, mem_addr, v.alu);
        if (v.e_we) check({v.name, "_wdata"}, mem_wdata, v.sd);
        check1({v.name, "_wb_early"}, wb_valid, 1'b0);
        if (i == v.ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        mem_rdata = 32'h0;
        @(negedge clk);
      end
    end
    check1({v.name, "_req_off"}, mem_req, 1'b0);
    check1({v.name, "_wb_valid"}, wb_valid, 1'b1);
    check1({v.name, "_wb_rw"}, wb_reg_write, v.e_rw);
    check({v.name, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
    check1({v.name, "_wb_err"}, wb_error, 1'b0);
    if (v.e_chk_data) sb_check({v.name, "_wb_data"}, wb_data);
    @(negedge clk);
    check1({v.name, "_wb_pulse"}, wb_valid, 1'b0);
    check({v.name, "_wb_rd_hold"}, 32'(wb_rd), 32'(v.rd));
    check({v.name, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0;
    mem_write = 1'b0; alu_result = '0; store_data = '0; rd = '0; mem_ack = 1'b0; mem_rdata = '0;

    //        name      rw  mr  m2r mw  alu           sd         rd  dly rdata         mem we  rw  chk data
    vecs[0] = mk("rtype", 1, 0, 0, 0, 32'h0000_002A, 32'h0,     5,  0, 32'h0,        0, 0, 1, 1, 32'h0000_002A);
    vecs[1] = mk("load",  1, 1, 1, 0, 32'h0000_0100, 32'h0,     7,  2, 32'hDEAD_BEEF, 1, 0, 1, 1, 32'hDEAD_BEEF);
    vecs[2] = mk("store", 1, 0, 0, 1, 32'h0000_0200, 32'h1234,  3,  0, 32'h5555_5555, 1, 1, 0, 0, 32'h0);
    vecs[3] = mk("ld_alu",1, 1, 0, 0, 32'h0000_0044, 32'h0,     9,  1, 32'hFFFF_0000, 1, 0, 1, 1, 32'h0000_0044);
    vecs[4] = mk("rdwr",  1, 1, 1, 1, 32'h0000_0300, 32'hCAFE,  4,  3, 32'h0000_0077, 1, 1, 0, 0, 32'h0);
    vecs[5] = mk("rd0",   1, 0, 0, 0, 32'h0000_0099, 32'h0,     0,  0, 32'h0,        0, 0, 0, 1, 32'h0000_0099);
    vecs[6] = mk("norw",  0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0,     31, 0, 32'h0,        0, 0, 0, 1, 32'hFFFF_FFFF);
    vecs[7] = mk("ld_late",1,1, 1, 0, 32'h0000_0500, 32'h0,     8,  3, 32'h0BAD_F00D, 1, 0, 1, 1, 32'h0BAD_F00D);

    // reset values
    #2;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check1("rst_wb_reg_write", wb_reg_write, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // stray ack while idle: nothing moves, wb_* keep the last retired values
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check1("stray_ack_wb_valid", wb_valid, 1'b0);
    check("stray_ack_wb_data", wb_data, 32'h0BAD_F00D);
    check("stray_ack_state", 32'(dbg_state), 32'd0);
    check1("stray_ack_req", mem_req, 1'b0);

    // in_valid held high: accepts only every second cycle, rd=0 never writes
    reg_write = 1'b1; mem_read = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0;
    alu_result = 32'h0000_005A; rd = 5'd0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check1("b2b_in_ready", in_ready, (i % 2) == 0);
      check1("b2b_wb_valid", wb_valid, (i % 2) == 1);
      if ((i % 2) == 1) begin
        check1("b2b_wb_rw", wb_reg_write, 1'b0);
        check("b2b_wb_data", wb_data, 32'h0000_005A);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // reset while a load is waiting for its ack
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 5'd10);
    @(negedge clk);
    check1("rstmid_req_before", mem_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("rstmid_req_async", mem_req, 1'b0);
    check1("rstmid_in_ready", in_ready, 1'b1);
    check("rstmid_state", 32'(dbg_state), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("rstmid_no_wb", wb_valid, 1'b0);
      check("rstmid_idle", 32'(dbg_state), 32'd0);
    end

`ifdef MEM_TIMEOUT_EN
    // load never acked: 4 request cycles then an error retire
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("tmo_req", mem_req, 1'b1);
      check1("tmo_wb_early", wb_valid, 1'b0);
    end
    @(negedge clk);
    check1("tmo_req_off", mem_req, 1'b0);
    check1("tmo_wb_valid", wb_valid, 1'b1);
    check1("tmo_wb_error", wb_error, 1'b1);
    check1("tmo_wb_rw", wb_reg_write, 1'b0);
    check("tmo_wb_rd", 32'(wb_rd), 32'd6);
    @(negedge clk);
    check1("tmo_pulse", wb_valid, 1'b0);
    check1("tmo_err_hold", wb_error, 1'b1);
`else
    // without the timeout a slow memory is simply waited for
    run_vec(mk("slow", 1, 1, 1, 0, 32'h0000_0700, 32'h0, 12, 80, 32'h1357_9BDF,
               1, 0, 1, 1, 32'h1357_9BDF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
